// File: rtl/sdram_init_seq_if.sv
// rtl/sdram_init_seq_if.sv - init sequencer to controller command mux bundle
interface sdram_init_seq_if #(
   parameter int ADDR_W = 13,
   parameter int BA_W   = 2
) ();
   logic              reinit_req;
   logic [3:0]        init_cmd;
   logic [BA_W-1:0]   init_bank_addr;
   logic [ADDR_W-1:0] init_addr;
   logic              init_end;
   logic              init_busy;

   modport master (
      input  reinit_req,
      output init_cmd, init_bank_addr, init_addr, init_end, init_busy
   );

   modport slave (
      output reinit_req,
      input  init_cmd, init_bank_addr, init_addr, init_end, init_busy
   );
endinterface

// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - SDRAM power-up init sequencer (PRE, AREF x N, MRS)
// Define SDRAM_EMRS_EN to append an extended mode-register set before INIT_END.
module sdram_init_seq #(
   parameter int                ADDR_W      = 13,
   parameter int                BA_W        = 2,
   parameter int                CNT_POWERUP = 19999,
   parameter int                T_RP        = 2,
   parameter int                T_RFC       = 7,
   parameter int                T_MRD       = 3,
   parameter int                AREF_NUM    = 8,
   parameter logic [2:0]        CAS_LAT     = 3'd3,
   parameter logic              BURST_TYPE  = 1'b0,
   parameter logic [2:0]        BURST_LEN   = 3'b111,
   parameter logic              WR_BURST    = 1'b0,
   parameter logic [ADDR_W-1:0] EMRS_VAL    = '0
) (
   input logic               clk,
   input logic               rst_n,
   sdram_init_seq_if.master  bus
);
   localparam int T_MAX  = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                          : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
   localparam int CLK_W  = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);
   localparam int PWR_W  = (CNT_POWERUP < 1) ? 1 : $clog2(CNT_POWERUP + 1);
   localparam int AREF_W = $clog2(AREF_NUM + 1);

   localparam logic [3:0] CMD_NOP  = 4'b1000;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0000;

   localparam logic [ADDR_W-1:0] MODE_WORD =
      ADDR_W'({WR_BURST, 2'b00, CAS_LAT, BURST_TYPE, BURST_LEN});

`ifdef SDRAM_EMRS_EN
   localparam int NS = 10;
`else
   localparam int NS = 8;
   logic unused_emrs;
   assign unused_emrs = ^EMRS_VAL;
`endif

   typedef enum logic [NS-1:0] {
      IDLE      = NS'(1),
      PRE_CHARG = NS'(2),
      WAIT_TRP  = NS'(4),
      AUTO_REF  = NS'(8),
      WAIT_TRFC = NS'(16),
      MOD_REG   = NS'(32),
      WAIT_TMRD = NS'(64),
      INIT_END  = NS'(128)
`ifdef SDRAM_EMRS_EN
      , EXT_MOD    = NS'(256),
      WAIT_TEMRD   = NS'(512)
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [PWR_W-1:0]    cnt_pwr_q, cnt_pwr_d;
   logic [CLK_W-1:0]    cnt_clk_q, cnt_clk_d;
   logic [AREF_W-1:0]   aref_cnt_q, aref_cnt_d;
   logic [3:0]          cmd_q, cmd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BA_W-1:0]     bank_q, bank_d;

   // Command fields decode the current state; registering them gives the 1-clk bus latency.
   always_comb begin
      state_d    = state_q;
      cnt_pwr_d  = cnt_pwr_q;
      cnt_clk_d  = cnt_clk_q;
      aref_cnt_d = aref_cnt_q;
      cmd_d      = CMD_NOP;
      addr_d     = '1;
      bank_d     = '1;
      case (state_q)
         IDLE: begin
            cnt_clk_d = '0;
            if (cnt_pwr_q == PWR_W'(CNT_POWERUP)) begin
               cnt_pwr_d = '0;
               state_d   = PRE_CHARG;
            end else begin
               cnt_pwr_d = cnt_pwr_q + 1'b1;
            end
         end
         PRE_CHARG: begin
            cmd_d   = CMD_PRE;
            state_d = WAIT_TRP;
         end
         WAIT_TRP: begin
            if (cnt_clk_q == CLK_W'(T_RP)) begin
               cnt_clk_d = '0;
               state_d   = AUTO_REF;
            end else begin
               cnt_clk_d = cnt_clk_q + 1'b1;
            end
         end
         AUTO_REF: begin
            cmd_d   = CMD_AREF;
            state_d = WAIT_TRFC;
         end
         WAIT_TRFC: begin
            if (cnt_clk_q == CLK_W'(T_RFC)) begin
               cnt_clk_d  = '0;
               aref_cnt_d = aref_cnt_q + 1'b1;
               state_d    = (aref_cnt_q == AREF_W'(AREF_NUM - 1)) ? MOD_REG : AUTO_REF;
            end else begin
               cnt_clk_d = cnt_clk_q + 1'b1;
            end
         end
         MOD_REG: begin
            cmd_d   = CMD_MRS;
            bank_d  = '0;
            addr_d  = MODE_WORD;
            state_d = WAIT_TMRD;
         end
         WAIT_TMRD: begin
            if (cnt_clk_q == CLK_W'(T_MRD)) begin
               cnt_clk_d = '0;
`ifdef SDRAM_EMRS_EN
               state_d   = EXT_MOD;
`else
               state_d   = INIT_END;
`endif
            end else begin
               cnt_clk_d = cnt_clk_q + 1'b1;
            end
         end
`ifdef SDRAM_EMRS_EN
         EXT_MOD: begin
            cmd_d   = CMD_MRS;
            bank_d  = BA_W'(2);
            addr_d  = EMRS_VAL;
            state_d = WAIT_TEMRD;
         end
         WAIT_TEMRD: begin
            if (cnt_clk_q == CLK_W'(T_MRD)) begin
               cnt_clk_d = '0;
               state_d   = INIT_END;
            end else begin
               cnt_clk_d = cnt_clk_q + 1'b1;
            end
         end
`endif
         INIT_END: begin
            cnt_clk_d = '0;
            if (bus.reinit_req) begin
               aref_cnt_d = '0;
               state_d    = PRE_CHARG;
            end
         end
         default: begin
            cnt_pwr_d  = '0;
            cnt_clk_d  = '0;
            aref_cnt_d = '0;
            state_d    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_pwr_q  <= '0;
         cnt_clk_q  <= '0;
         aref_cnt_q <= '0;
         cmd_q      <= CMD_NOP;
         addr_q     <= '1;
         bank_q     <= '1;
      end else begin
         state_q    <= state_d;
         cnt_pwr_q  <= cnt_pwr_d;
         cnt_clk_q  <= cnt_clk_d;
         aref_cnt_q <= aref_cnt_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         bank_q     <= bank_d;
      end
   end

   assign bus.init_cmd       = cmd_q;
   assign bus.init_addr      = addr_q;
   assign bus.init_bank_addr = bank_q;
   assign bus.init_end       = (state_q == INIT_END);
   assign bus.init_busy      = (state_q != INIT_END);
endmodule

// File: tb/tb_sdram_init_seq.sv
// tb/tb_sdram_init_seq.sv - scoreboard bench for sdram_init_seq (AREF_NUM 2 and 8 instances)
module tb_sdram_init_seq;
   localparam int T_RP  = 2;
   localparam int T_RFC = 7;
   localparam int T_MRD = 3;
   localparam logic [3:0]  NOP  = 4'b1000;
   localparam logic [3:0]  PRE  = 4'b0010;
   localparam logic [3:0]  AREF = 4'b0001;
   localparam logic [3:0]  MRS  = 4'b0000;
   localparam logic [12:0] ONES = 13'h1fff;
   localparam logic [12:0] MODE = 13'h037;
   localparam int K_CMD  = 0;
   localparam int K_RISE = 1;
   localparam int K_FALL = 2;

   typedef struct {
      int          at;
      int          kind;
      logic [3:0]  cmd;
      logic [1:0]  bank;
      logic [12:0] addr;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   edge_cnt;
   int   n_tests = 0;
   int   n_fail = 0;
   ev_t  q_a[$];
   ev_t  q_b[$];
   logic prev_end_a, prev_end_b;

   sdram_init_seq_if #(.ADDR_W(13), .BA_W(2)) if_a ();
   sdram_init_seq_if #(.ADDR_W(13), .BA_W(2)) if_b ();

   sdram_init_seq #(
      .CNT_POWERUP(9), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD), .AREF_NUM(2),
      .CAS_LAT(3'd3), .BURST_LEN(3'b111), .EMRS_VAL(13'h0020)
   ) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.master));

   sdram_init_seq #(
      .CNT_POWERUP(9), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD), .AREF_NUM(8),
      .CAS_LAT(3'd3), .BURST_LEN(3'b111)
   ) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.master));

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   task automatic push_ev(input int ch, input int at, input int kind, input logic [3:0] cmd,
                          input logic [1:0] bank, input logic [12:0] addr);
      ev_t e;
      e = '{at: at, kind: kind, cmd: cmd, bank: bank, addr: addr};
      if (ch == 0) q_a.push_back(e);
      else         q_b.push_back(e);
   endtask

   // Full sequence starting with PRE on the bus at edge 'pre'.
   task automatic push_seq(input int ch, input int pre, input int nref, input logic [12:0] emrs);
      int t;
      push_ev(ch, pre, K_CMD, PRE, 2'b11, ONES);
      t = pre + T_RP + 2;
      for (int k = 0; k < nref; k++) begin
         push_ev(ch, t, K_CMD, AREF, 2'b11, ONES);
         t = t + T_RFC + 2;
      end
      push_ev(ch, t, K_CMD, MRS, 2'b00, MODE);
`ifdef SDRAM_EMRS_EN
      t = t + T_MRD + 2;
      push_ev(ch, t, K_CMD, MRS, 2'b10, emrs);
`endif
      push_ev(ch, t + T_MRD + 1, K_RISE, NOP, 2'b11, ONES);
   endtask

   task automatic check_ev(input int ch, input int kind, input logic [3:0] cmd,
                           input logic [1:0] bank, input logic [12:0] addr);
      ev_t e;
      bit  have;
      have = 1'b0;
      if (ch == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      if (ch == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      n_tests++;
      if (!have) begin
         n_fail++;
         $display("FAIL unexpected_event ch%0d: got kind %0d cmd %b bank %0d addr %h at edge %0d, required none",
                  ch, kind, cmd, bank, addr, edge_cnt);
      end else if (e.kind != kind || e.at != edge_cnt ||
                   (kind == K_CMD && (e.cmd != cmd || e.bank != bank || e.addr != addr))) begin
         n_fail++;
         $display("FAIL event ch%0d: got kind %0d cmd %b bank %0d addr %h edge %0d, required kind %0d cmd %b bank %0d addr %h edge %0d",
                  ch, kind, cmd, bank, addr, edge_cnt, e.kind, e.cmd, e.bank, e.addr, e.at);
      end
   endtask

   task automatic mon_ch(input int ch, input logic [3:0] cmd, input logic [1:0] bank,
                         input logic [12:0] addr, input logic iend, input logic busy, input logic prev);
      if (cmd != NOP) check_ev(ch, K_CMD, cmd, bank, addr);
      else begin
         n_tests++;
         if (addr != ONES || bank != 2'b11) begin
            n_fail++;
            $display("FAIL nop_bus ch%0d edge %0d: got addr %h bank %0d, required 1fff bank 3",
                     ch, edge_cnt, addr, bank);
         end
      end
      if (iend && !prev) check_ev(ch, K_RISE, NOP, 2'b11, ONES);
      if (!iend && prev) check_ev(ch, K_FALL, NOP, 2'b11, ONES);
      n_tests++;
      if (busy != !iend) begin
         n_fail++;
         $display("FAIL busy ch%0d edge %0d: got busy %b, required %b", ch, edge_cnt, busy, !iend);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_end_a <= 1'b0;
         prev_end_b <= 1'b0;
      end else begin
         mon_ch(0, if_a.init_cmd, if_a.init_bank_addr, if_a.init_addr, if_a.init_end, if_a.init_busy, prev_end_a);
         mon_ch(1, if_b.init_cmd, if_b.init_bank_addr, if_b.init_addr, if_b.init_end, if_b.init_busy, prev_end_b);
         prev_end_a <= if_a.init_end;
         prev_end_b <= if_b.init_end;
      end
   end

   task automatic chk(input string name, input int got, input int req);
      n_tests++;
      if (got != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic check_reset();
      chk("rst_cmd_a",  int'(if_a.init_cmd), int'(NOP));
      chk("rst_addr_a", int'(if_a.init_addr), int'(ONES));
      chk("rst_bank_a", int'(if_a.init_bank_addr), 3);
      chk("rst_end_a",  int'(if_a.init_end), 0);
      chk("rst_busy_a", int'(if_a.init_busy), 1);
      chk("rst_cmd_b",  int'(if_b.init_cmd), int'(NOP));
      chk("rst_addr_b", int'(if_b.init_addr), int'(ONES));
      chk("rst_bank_b", int'(if_b.init_bank_addr), 3);
      chk("rst_end_b",  int'(if_b.init_end), 0);
      chk("rst_busy_b", int'(if_b.init_busy), 1);
   endtask

   task automatic wait_edge(input int n);
      while (edge_cnt < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int ch);
      if (ch == 0) if_a.reinit_req = 1'b1;
      else         if_b.reinit_req = 1'b1;
      @(posedge clk);
      #1;
      if_a.reinit_req = 1'b0;
      if_b.reinit_req = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      if_a.reinit_req = 1'b0;
      if_b.reinit_req = 1'b0;
      repeat (3) @(negedge clk);
      check_reset();
      push_seq(0, 11, 2, 13'h0020);
      push_seq(1, 11, 8, 13'h0000);
      rst_n = 1'b1;

      // Request during B's WAIT_TRFC (sampled at edge 30) must be ignored.
      wait_edge(29);
      pulse(1);
      wait_edge(100);
      chk("q_a_empty_p1", q_a.size(), 0);
      chk("q_b_empty_p1", q_b.size(), 0);

      // Re-init from INIT_END, then an ignored request during WAIT_TRFC at edge 110.
      push_ev(0, 101, K_FALL, NOP, 2'b11, ONES);
      push_seq(0, 102, 2, 13'h0020);
      pulse(0);
      wait_edge(109);
      pulse(0);
      wait_edge(140);
      chk("q_a_empty_p2", q_a.size(), 0);

      // Re-init again, then reset while A sits in WAIT_TRFC.
      push_ev(0, 141, K_FALL, NOP, 2'b11, ONES);
      push_ev(0, 142, K_CMD, PRE, 2'b11, ONES);
      push_ev(0, 146, K_CMD, AREF, 2'b11, ONES);
      pulse(0);
      wait_edge(150);
      rst_n = 1'b0;
      #1;
      check_reset();
      chk("q_a_empty_p3", q_a.size(), 0);
      chk("q_b_empty_p3", q_b.size(), 0);
      repeat (2) @(negedge clk);
      push_seq(0, 11, 2, 13'h0020);
      push_seq(1, 11, 8, 13'h0000);
      rst_n = 1'b1;
      wait_edge(100);
      chk("q_a_empty_p4", q_a.size(), 0);
      chk("q_b_empty_p4", q_b.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
